spi_slv16: RTL and testbench

SPI_SLV16 -- requirements
Module: spi_slv16

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_sync_edge.sv | 37 +++
 rtl/spi_slv16.sv | 195 +++++++++++++++++++
 tb/tb_spi_slv16.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the 16-bit SPI slave: word width, counter sizing
// and the frame-level FSM state encoding.
package spi_pkg;

  localparam int SPI_WORD_W = 16;
  localparam int SPI_CNT_W  = 5;

  localparam logic [SPI_CNT_W-1:0] SPI_CNT_MAX  = 5'd31;
  localparam logic [SPI_CNT_W-1:0] SPI_CNT_FULL = 5'd16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer followed by a history flop. A change between the
// synchronized level and the history flop is reported as a one-clk rise or
// fall pulse. All three flops preset to PRESET_VAL so an input idling at
// that level produces no edge when reset is released.
module spi_sync_edge #(
  parameter logic PRESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic hist_q;

  // Synchronizer chain plus history flop, all preset on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= PRESET_VAL;
      sync_q <= PRESET_VAL;
      hist_q <= PRESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~hist_q;
  assign fall_o  = ~sync_q & hist_q;

endmodule

// File: rtl/spi_slv16.sv
// 16-bit SPI slave, mode 3 style (SCLK idles high, data sampled at SCLK
// rise). All serial inputs are oversampled by clk. A frame opens on an SS_n
// fall, shifts one bit per SCLK rise and closes on an SS_n rise; only a
// frame of exactly 16 rises updates cmd/rdy, anything else flags frm_err.
module spi_slv16
  import spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SS_n,
  input  logic                  SCLK,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic [SPI_WORD_W-1:0] tx_data,
  input  logic                  wrt_tx,
  output logic [SPI_WORD_W-1:0] cmd,
  output logic                  rdy,
  input  logic                  clr_rdy,
  output logic                  ovr,
  output logic                  frm_err
);

  spi_state_e state_q, state_d;

  logic [SPI_WORD_W-1:0] shiftReg_q, shiftReg_d;
  logic [SPI_WORD_W-1:0] txBuf_q, txBuf_d;
  logic [SPI_WORD_W-1:0] cmd_q, cmd_d;
  logic [SPI_CNT_W-1:0]  riseCnt_q, riseCnt_d;
  logic                  rdy_q, rdy_d;
  logic                  ovr_q, ovr_d;
  logic                  frmErr_q, frmErr_d;
  logic                  mosiMeta_q, mosiSync_q;
  logic [1:0]            settleCnt_q;
  logic                  armed_q;

  logic ssLevel, ssRise, ssFall;
  logic sclkLevel, sclkRise, sclkFall;
  logic loadShift, doShift, frameEnd, frameOk, misoD;
  logic unusedSclk;

  spi_sync_edge #(.PRESET_VAL(1'b1)) u_ssSync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (SS_n),
    .level_o (ssLevel),
    .rise_o  (ssRise),
    .fall_o  (ssFall)
  );

  spi_sync_edge #(.PRESET_VAL(1'b1)) u_sclkSync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (SCLK),
    .level_o (sclkLevel),
    .rise_o  (sclkRise),
    .fall_o  (sclkFall)
  );

  // SCLK falls and the raw SCLK level play no part in this protocol
  assign unusedSclk = sclkFall ^ sclkLevel;

  // MOSI only needs a plain two-flop synchronizer; it is stable around SCLK rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosiMeta_q <= 1'b0;
      mosiSync_q <= 1'b0;
    end else begin
      mosiMeta_q <= MOSI;
      mosiSync_q <= mosiMeta_q;
    end
  end

  // Arm frame starts only once SS_n has been seen high after the synchronizer
  // has flushed its preset, so a select held low through reset is ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settleCnt_q <= 2'd0;
      armed_q     <= 1'b0;
    end else begin
      if (settleCnt_q != 2'd3) begin
        settleCnt_q <= settleCnt_q + 2'd1;
      end
      if (settleCnt_q == 2'd3 && ssLevel) begin
        armed_q <= 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: SS_n fall opens a frame, SS_n rise closes it
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ssFall && armed_q) state_d = ACTIVE;
      ACTIVE:  if (ssRise)            state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: load/shift strobes, frame-end strobe and MISO
  always_comb begin
    loadShift = 1'b0;
    doShift   = 1'b0;
    frameEnd  = 1'b0;
    misoD     = 1'b0;
    case (state_q)
      IDLE: begin
        loadShift = ssFall && armed_q;
      end
      ACTIVE: begin
        doShift  = sclkRise;
        frameEnd = ssRise;
        misoD    = shiftReg_q[SPI_WORD_W-1];
      end
      default: begin
        misoD = 1'b0;
      end
    endcase
  end

  assign MISO = misoD;

  // Datapath next state: tx buffer, shift register, rise counter and results
  always_comb begin
    txBuf_d    = wrt_tx ? tx_data : txBuf_q;
    shiftReg_d = shiftReg_q;
    riseCnt_d  = riseCnt_q;
    frameOk    = frameEnd && (riseCnt_q == SPI_CNT_FULL);
    cmd_d      = cmd_q;
    rdy_d      = rdy_q;
    ovr_d      = ovr_q;
    frmErr_d   = frmErr_q;

    if (loadShift) begin
      shiftReg_d = txBuf_d;
      riseCnt_d  = '0;
    end else if (doShift) begin
      shiftReg_d = {shiftReg_q[SPI_WORD_W-2:0], mosiSync_q};
      if (riseCnt_q != SPI_CNT_MAX) begin
        riseCnt_d = riseCnt_q + 5'd1;
      end
    end

    if (clr_rdy) begin
      rdy_d    = 1'b0;
      ovr_d    = 1'b0;
      frmErr_d = 1'b0;
    end

    if (frameOk) begin
      cmd_d = shiftReg_q;
      rdy_d = 1'b1;
      if (rdy_q && !clr_rdy) begin
        ovr_d = 1'b1;
      end
    end else if (frameEnd) begin
      frmErr_d = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shiftReg_q <= '0;
      txBuf_q    <= '0;
      riseCnt_q  <= '0;
      cmd_q      <= '0;
      rdy_q      <= 1'b0;
      ovr_q      <= 1'b0;
      frmErr_q   <= 1'b0;
    end else begin
      shiftReg_q <= shiftReg_d;
      txBuf_q    <= txBuf_d;
      riseCnt_q  <= riseCnt_d;
      cmd_q      <= cmd_d;
      rdy_q      <= rdy_d;
      ovr_q      <= ovr_d;
      frmErr_q   <= frmErr_d;
    end
  end

  assign cmd     = cmd_q;
  assign rdy     = rdy_q;
  assign ovr     = ovr_q;
  assign frm_err = frmErr_q;

endmodule

// File: tb/tb_spi_slv16.sv
// Bench for spi_slv16: acts as an SPI master and keeps a frame-level model
// of what the slave must report (cmd, rdy, ovr, frm_err, returned word).
module tb_spi_slv16;

  logic        clk;
  logic        rst_n;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic [15:0] tx_data;
  logic        wrt_tx;
  logic [15:0] cmd;
  logic        rdy;
  logic        clr_rdy;
  logic        ovr;
  logic        frm_err;

  int errors = 0;
  int checks = 0;

  logic [15:0] mCmd;
  bit          mRdy, mOvr, mFrm;
  logic [15:0] mTx;
  bit          idleQuiet;
  bit          cmpOn;
  logic [15:0] mw;

  spi_slv16 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .tx_data (tx_data),
    .wrt_tx  (wrt_tx),
    .cmd     (cmd),
    .rdy     (rdy),
    .clr_rdy (clr_rdy),
    .ovr     (ovr),
    .frm_err (frm_err)
  );

  // Free-running system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison of the status outputs against the frame-level model
  always @(negedge clk) begin
    if (cmpOn) begin
      checkOutput("cmd", cmd, mCmd);
      checkOutput("rdy", 16'(rdy), 16'(mRdy));
      checkOutput("ovr", 16'(ovr), 16'(mOvr));
      checkOutput("frm_err", 16'(frm_err), 16'(mFrm));
      if (idleQuiet) checkOutput("miso_idle", 16'(MISO), 16'h0);
    end
  end

  // Watchdog so the run always ends
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic writeTx(input logic [15:0] w);
    tx_data = w;
    wrt_tx  = 1'b1;
    waitClk(1);
    wrt_tx  = 1'b0;
    mTx     = w;
  endtask

  task automatic clearRdy();
    clr_rdy = 1'b1;
    waitClk(1);
    clr_rdy = 1'b0;
    mRdy = 1'b0;
    mOvr = 1'b0;
    mFrm = 1'b0;
  endtask

  task automatic sendBit(input logic b, output logic m);
    SCLK = 1'b0;
    MOSI = b;
    waitClk(8);
    m    = MISO;
    SCLK = 1'b1;
    waitClk(8);
  endtask

  // Close a frame; the slave result lands on the 3rd clk edge after SS_n rises
  task automatic ssHigh(input int nBits, input logic [15:0] word, input bit clr);
    bit good;
    bit newOvr, newRdy, newFrm;
    waitClk(4);
    SS_n = 1'b1;
    waitClk(2);
    if (clr) clr_rdy = 1'b1;
    waitClk(1);
    clr_rdy = 1'b0;
    good   = (nBits == 16);
    newOvr = (mOvr && !clr) || (good && mRdy && !clr);
    newRdy = good ? 1'b1 : (clr ? 1'b0 : mRdy);
    newFrm = !good ? 1'b1 : (clr ? 1'b0 : mFrm);
    if (good) mCmd = word;
    mOvr = newOvr;
    mRdy = newRdy;
    mFrm = newFrm;
    idleQuiet = 1'b1;
  endtask

  // One master frame of nBits SCLK pulses; optionally rewrites tx mid-frame
  task automatic applyStimulus(input logic [15:0] mosiWord, input int nBits, input bit clr,
                               input bit midWrite, input logic [15:0] midWord,
                               output logic [15:0] misoWord);
    logic [15:0] txAtStart;
    logic [15:0] mask;
    logic        b, m;
    misoWord  = 16'h0;
    idleQuiet = 1'b0;
    SS_n      = 1'b0;
    txAtStart = mTx;
    waitClk(10);
    for (int i = 0; i < nBits; i++) begin
      b = (i < 16) ? mosiWord[15-i] : 1'($urandom);
      sendBit(b, m);
      if (i < 16) misoWord[15-i] = m;
      if (midWrite && i == 5) writeTx(midWord);
    end
    ssHigh(nBits, mosiWord, clr);
    mask = (nBits >= 16) ? 16'hFFFF : ~(16'hFFFF >> nBits);
    checkOutput("miso_word", misoWord & mask, txAtStart & mask);
    waitClk(3);
  endtask

  initial begin
    logic m;
    logic [15:0] w;
    int          n;
    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    tx_data = 16'h0; wrt_tx = 1'b0; clr_rdy = 1'b0;
    mCmd = 16'h0; mRdy = 1'b0; mOvr = 1'b0; mFrm = 1'b0; mTx = 16'h0;
    idleQuiet = 1'b1; cmpOn = 1'b0;
    waitClk(3);
    rst_n = 1'b1;
    cmpOn = 1'b1;
    checkOutput("reset_cmd", cmd, 16'h0);
    checkOutput("reset_rdy", 16'(rdy), 16'h0);
    waitClk(6);

    // Basic exchange
    writeTx(16'hA5C3);
    applyStimulus(16'h1234, 16, 1'b0, 1'b0, 16'h0, mw);
    checkOutput("t1_miso", mw, 16'hA5C3);
    checkOutput("t1_cmd", cmd, 16'h1234);
    checkOutput("t1_rdy", 16'(rdy), 16'h1);
    checkOutput("t1_ovr", 16'(ovr), 16'h0);

    // Overrun, tx buffer retained
    applyStimulus(16'hBEEF, 16, 1'b0, 1'b0, 16'h0, mw);
    checkOutput("t2_miso", mw, 16'hA5C3);
    checkOutput("t2_cmd", cmd, 16'hBEEF);
    checkOutput("t2_ovr", 16'(ovr), 16'h1);

    // Short frame
    applyStimulus(16'hFFFF, 10, 1'b0, 1'b0, 16'h0, mw);
    checkOutput("t3_frm", 16'(frm_err), 16'h1);
    checkOutput("t3_cmd", cmd, 16'hBEEF);
    checkOutput("t3_rdy", 16'(rdy), 16'h1);
    clearRdy();
    waitClk(1);
    checkOutput("clr_all", {13'h0, rdy, ovr, frm_err}, 16'h0);

    // Mid-frame tx write only affects the next frame
    applyStimulus(16'h1111, 16, 1'b0, 1'b1, 16'h0F0F, mw);
    checkOutput("t4_old", mw, 16'hA5C3);
    applyStimulus(16'h2222, 16, 1'b0, 1'b0, 16'h0, mw);
    checkOutput("t4_new", mw, 16'h0F0F);

    // clr_rdy coincident with the frame-end update
    applyStimulus(16'h3333, 16, 1'b1, 1'b0, 16'h0, mw);
    checkOutput("t6_rdy", 16'(rdy), 16'h1);
    checkOutput("t6_ovr", 16'(ovr), 16'h0);
    checkOutput("t6_cmd", cmd, 16'h3333);

    // Reset mid-frame with SS_n held low through release
    idleQuiet = 1'b0;
    SS_n = 1'b0;
    waitClk(10);
    for (int i = 0; i < 7; i++) sendBit(1'($urandom), m);
    rst_n = 1'b0;
    mCmd = 16'h0; mRdy = 1'b0; mOvr = 1'b0; mFrm = 1'b0; mTx = 16'h0;
    idleQuiet = 1'b1;
    waitClk(3);
    rst_n = 1'b1;
    waitClk(2);
    checkOutput("t5_outs", {cmd[15:4], cmd[3:0] | {rdy, ovr, frm_err, MISO}}, 16'h0);
    for (int i = 0; i < 16; i++) sendBit(1'($urandom), m);
    SS_n = 1'b1;
    waitClk(6);
    checkOutput("t5_no_rdy", 16'(rdy), 16'h0);
    checkOutput("t5_no_frm", 16'(frm_err), 16'h0);
    applyStimulus(16'hC0DE, 16, 1'b0, 1'b0, 16'h0, mw);
    checkOutput("t5_miso", mw, 16'h0);
    checkOutput("t5_cmd", cmd, 16'hC0DE);
    checkOutput("t5_rdy", 16'(rdy), 16'h1);

    // Randomized frames
    for (int k = 0; k < 14; k++) begin
      if ($urandom % 3 == 0) writeTx(16'($urandom));
      if ($urandom % 4 == 0) clearRdy();
      n = ($urandom % 5 == 0) ? int'($urandom_range(1, 20)) : 16;
      w = 16'($urandom);
      applyStimulus(w, n, ($urandom % 4) == 0, ($urandom % 4) == 0, 16'($urandom), mw);
    end

    waitClk(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
